// File: rtl/counter_chain_param.sv
// counter_chain_param
//   Parameterised up/down/step/load counter. The counter is built from NS slices
//   of SLICE bits each, and it reports the carry-out or borrow-out of every slice.
//   Wrap or saturate behaviour is selectable on each cycle.
//   Every output is registered, so results appear one cycle after the sampling edge.
//
// Ports
//   cp_clk    : rising-edge clock
//   cp_reset  : synchronous active-high reset; overrides every other input
//   cp_enable : 1 = perform the operation selected by cp_mode; 0 = hold
//   cp_mode   : 00 up by 1, 01 down by 1, 10 down by cp_step, 11 load cp_D
//   cp_D      : load value (mode 11)
//   cp_step   : step for mode 10, zero-extended to WIDTH
//   cp_sat    : 1 = saturate at the bounds, 0 = wrap modulo 2^WIDTH
//   cp_term   : terminal-count compare value
//   cp_Q      : registered count
//   cp_rco    : per-slice carry/borrow-out pulses
//   cp_load   : load-indicator pulses (all ones after a load)
//   cp_ovf    : wrap/saturation pulse
//   cp_tc     : cp_Q equals the cp_term value sampled at the same edge
module counter_chain_param #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SLICE  = 4,
  parameter int unsigned STEP_W = 4
) (
  input  logic                      cp_clk,
  input  logic                      cp_reset,
  input  logic                      cp_enable,
  input  logic [1:0]                cp_mode,
  input  logic [WIDTH-1:0]          cp_D,
  input  logic [STEP_W-1:0]         cp_step,
  input  logic                      cp_sat,
  input  logic [WIDTH-1:0]          cp_term,
  output logic [WIDTH-1:0]          cp_Q,
  output logic [WIDTH/SLICE-1:0]    cp_rco,
  output logic [WIDTH/SLICE-1:0]    cp_load,
  output logic                      cp_ovf,
  output logic                      cp_tc
);

  localparam int unsigned NS = WIDTH / SLICE;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DN      = 2'b01,
    MODE_DN_STEP = 2'b10,
    MODE_LOAD    = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(cp_mode);

  logic [WIDTH-1:0] q_q,    q_d;
  logic [NS-1:0]    rco_q,  rco_d;
  logic [NS-1:0]    load_q, load_d;
  logic             ovf_q,  ovf_d;
  logic             tc_q,   tc_d;

  logic [WIDTH:0]   opa, opb, res;
  logic [NS-1:0]    slice_c;

  // One WIDTH+1-bit add/subtract. Bit WIDTH is the word carry or borrow.
  always_comb begin
    opa = {1'b0, q_q};
    opb = '0;
    unique case (mode)
      MODE_UP, MODE_DN: opb = (WIDTH+1)'(1);
      MODE_DN_STEP:     opb[STEP_W-1:0] = cp_step;
      default:          opb = '0;
    endcase
    res = (mode == MODE_UP) ? (opa + opb) : (opa - opb);
  end

  // The carry (or borrow) into bit k is res[k] ^ opa[k] ^ opb[k].
  // The carry-out of slice i is therefore the carry into bit (i+1)*SLICE.
  always_comb begin
    slice_c = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      slice_c[i] = res[(i+1)*SLICE] ^ opa[(i+1)*SLICE] ^ opb[(i+1)*SLICE];
    end
  end

  always_comb begin
    q_d    = q_q;
    rco_d  = '0;
    load_d = '0;
    ovf_d  = 1'b0;
    if (cp_reset) begin
      q_d = '0;
    end else if (cp_enable) begin
      if (mode == MODE_LOAD) begin
        q_d    = cp_D;
        load_d = '1;
      end else if (res[WIDTH]) begin
        ovf_d = 1'b1;
        if (cp_sat) begin
          q_d = (mode == MODE_UP) ? '1 : '0;
        end else begin
          q_d   = res[WIDTH-1:0];
          rco_d = slice_c;
        end
      end else begin
        q_d   = res[WIDTH-1:0];
        rco_d = slice_c;
      end
    end
    tc_d = !cp_reset && (q_d == cp_term);
  end

  always_ff @(posedge cp_clk) begin
    if (cp_reset) begin
      q_q    <= '0;
      rco_q  <= '0;
      load_q <= '0;
      ovf_q  <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      rco_q  <= rco_d;
      load_q <= load_d;
      ovf_q  <= ovf_d;
      tc_q   <= tc_d;
    end
  end

  assign cp_Q    = q_q;
  assign cp_rco  = rco_q;
  assign cp_load = load_q;
  assign cp_ovf  = ovf_q;
  assign cp_tc   = tc_q;

endmodule

// File: doc/counter_chain_param.md
COUNTER_CHAIN_PARAM -- requirements
Module: counter_chain_param

Interface
REQ-001 Parameter WIDTH, default 32: counter width in bits; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 4: slice width for per-slice carry/load flags; NS = WIDTH/SLICE.
REQ-003 Parameter STEP_W, default 4: width of the programmable step input.
REQ-004 The module SHALL have one clock, cp_clk; reset cp_reset is synchronous and active-high.
REQ-005 cp_clk  in  1  rising-edge clock for all state.
REQ-006 cp_reset  in  1  synchronous active-high reset; dominates all other inputs.
REQ-007 cp_enable  in  1  1 = perform the operation selected by cp_mode this cycle; 0 = hold.
REQ-008 cp_mode  in  2  00 up by 1, 01 down by 1, 10 down by cp_step, 11 load cp_D.
REQ-009 cp_D  in  WIDTH  load value for mode 11.
REQ-010 cp_step  in  STEP_W  step for mode 10, zero-extended to WIDTH.
REQ-011 cp_sat  in  1  1 = saturate at bounds; 0 = wrap modulo 2^WIDTH.
REQ-012 cp_term  in  WIDTH  terminal-count compare value.
REQ-013 cp_Q  out  WIDTH  registered count.
REQ-014 cp_rco  out  NS  registered per-slice carry/borrow-out pulses.
REQ-015 cp_load  out  NS  registered load-indicator pulses.
REQ-016 cp_ovf  out  1  registered pulse: wrap or saturation occurred.
REQ-017 cp_tc  out  1  registered flag: cp_Q equals cp_term.

Function
REQ-018 All outputs SHALL be registered; results of an operation sampled at edge k SHALL appear after edge k (latency 1).
REQ-019 Mode 00: next = Q + 1; mode 01: next = Q - 1; mode 10: next = Q - zext(cp_step); mode 11: next = cp_D.
REQ-020 Arithmetic SHALL use a WIDTH+1-bit result; bit WIDTH is the word carry (up) or borrow (down).
REQ-021 cp_rco[i] SHALL equal the carry-out (modes 00) or borrow-out (modes 01/10) of slice i for the computed operation, for one cycle.
REQ-022 cp_rco SHALL be all zero in mode 11, when cp_enable = 0, and on a saturating cycle.
REQ-023 Mode 11 with cp_enable = 1: cp_load SHALL be all ones for exactly one cycle; otherwise all zero.
REQ-024 cp_sat = 0: word carry/borrow SHALL wrap the count (all-ones+1 -> 0, 0-1 -> all-ones) and pulse cp_ovf.
REQ-025 cp_sat = 1: would-overflow SHALL hold cp_Q at all-ones, would-underflow SHALL hold cp_Q at 0, and pulse cp_ovf.
REQ-026 cp_ovf SHALL be 0 in mode 11 and when cp_enable = 0.
REQ-027 cp_step = 0 in mode 10 SHALL leave cp_Q unchanged with cp_rco = 0 and cp_ovf = 0.
REQ-028 cp_enable = 0: cp_Q SHALL hold; cp_rco, cp_load, cp_ovf SHALL be 0.
REQ-029 cp_tc SHALL be 1 in the cycle after an edge at which the next cp_Q equals cp_term sampled at that edge; otherwise 0.
REQ-030 cp_sat and cp_mode SHALL be sampled every cycle; changing them between cycles SHALL take effect at the next edge with no extra latency.

Reset
REQ-031 cp_reset = 1 at an edge SHALL set cp_Q = 0, cp_rco = 0, cp_load = 0, cp_ovf = 0, cp_tc = 0, regardless of cp_enable or cp_mode.
REQ-032 Reset asserted mid-count SHALL abandon the in-progress operation; the first enabled edge after release SHALL operate from cp_Q = 0.

Verification (WIDTH=32, SLICE=4, STEP_W=4)
REQ-033 Reset, then mode 00, enable, 16 cycles -> cp_Q = 0x10; cp_rco = 8'h01 in the cycle cp_Q goes 0xF -> 0x10.
REQ-034 Load cp_D = 0xFFFF_FFFE (mode 11), then mode 00 x2, cp_sat = 0 -> cp_load = 8'hFF for 1 cycle; cp_Q = 0xFFFF_FFFF, then 0 with cp_rco = 8'hFF and cp_ovf = 1.
REQ-035 Same as REQ-034 with cp_sat = 1 -> cp_Q holds 0xFFFF_FFFF, cp_ovf = 1, cp_rco = 0.
REQ-036 Load 0x10, mode 10, cp_step = 3, 6 cycles, cp_sat = 0 -> cp_Q: 0xD, 0xA, 0x7, 0x4, 0x1, 0xFFFF_FFFE (cp_ovf = 1 on last); first step cp_rco = 8'h01.
REQ-037 cp_term = 5, count up from 0 -> cp_tc = 1 only in the cycle cp_Q = 5.
REQ-038 Counting at 0x1234 with cp_reset = 1 and cp_enable = 1 -> next cycle all outputs 0; after release counting resumes from 0 (1, 2, ...).
